id_issue_ctrl: RTL and testbench
================================

Name: id_issue_ctrl

Overview:
- Decode-stage issue controller for the AdamRiscv core.
- Holds one fetched instruction in the ID slot and generates its immediate via the existing imm_gen instance.
- Hands the instruction to EX over a valid/ready handshake, inserts the load-use bubble, and services branch/jump flushes from EX.
- Sits between the IF output register and the EX input register.

Parameters:
- CNT_W, 16, width of the saturating bubble-cycle counter.
- ISSUE_W, 32, width of the wrapping issued-instruction counter.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- if_valid  in  1  IF presents an instruction.
- if_inst  in  32  instruction word.
- if_pc  in  32  instruction PC.
- if_ready  out  1  ID slot accepts this cycle.
- flush  in  1  EX redirect (taken branch/jal/jalr); kills ID contents.
- ex_valid  out  1  issue request to EX.
- ex_ready  in  1  EX accepts.
- ex_inst  out  32  issued instruction.
- ex_pc  out  32  issued PC.
- ex_imm  out  32  imm_gen output for ex_inst.
- ex_rs1, ex_rs2, ex_rd  out  5 each  inst[19:15], inst[24:20], inst[11:7].
- ex_is_load  out  1  opcode 0000011.
- ex_illegal  out  1  opcode outside the supported set.
- bubble_cnt  out  CNT_W  load-use bubble cycles, saturating at all-ones.
- issue_cnt  out  ISSUE_W  issued instructions, wraps to 0.

Behaviour:
- Reset (async, rstn=0):
  - slot empty, ld_pending=0, ld_rd=0.
  - All ex_* data outputs 0, ex_valid=0, if_ready=0 while rstn=0, counters 0.
  - Reset mid-handshake discards the slot; no issue is counted.
- Supported opcodes: 0000011, 0010011, 1100111, 0100011, 1100011, 0110111, 0010111, 1101111, 0110011. Any other opcode: ex_illegal=1, ex_imm=0, instruction still issues normally.
- Register usage:
  - rs1 used by all supported opcodes except 0110111, 0010111, 1101111.
  - rs2 used only by 0100011, 1100011, 0110011.
- States:
  - EMPTY: slot invalid.
  - FULL: slot valid, no hazard.
  - BUBBLE: slot valid, and ld_pending=1 and ld_rd!=0 and (used rs1==ld_rd or used rs2==ld_rd).
- Outputs:
  - ex_valid=1 only in FULL.
  - ex_fire=ex_valid&ex_ready.
  - if_ready = !flush & (EMPTY | ex_fire).
- Load tracking:
  - On ex_fire with ex_is_load=1 and ex_rd!=0: ld_pending<=1, ld_rd<=ex_rd.
  - Otherwise ld_pending<=0 on every edge. Every edge counts, including BUBBLE cycles and FULL cycles with ex_ready=0, so a bubble lasts exactly one cycle.
- Transitions (priority order):
  1. flush=1 → EMPTY, ld_pending<=0. Incoming if_valid is dropped because if_ready=0. ex_fire is suppressed: ex_valid is forced 0 in the flush cycle.
  2. EMPTY & if_valid → slot loads; next state is FULL or BUBBLE per the hazard check against the updated ld_pending.
  3. FULL & ex_fire & if_valid → slot reloads, no idle cycle. This gives back-to-back issue of 1 instr/cycle.
  4. FULL & ex_fire & !if_valid → EMPTY.
  5. FULL & !ex_ready → hold; all ex_* outputs stable.
  6. BUBBLE → FULL next cycle; bubble_cnt += 1, saturating.
- ex_imm is combinational from the slot register (imm_gen), valid in the same cycle as ex_inst.
- issue_cnt increments on each ex_fire; wraps from all-ones to 0.
- Simultaneous load issue and hazard-free reload: the new instruction is checked against the newly issued load's rd.

Test Plan:
- Reset then stream `addi x1,x0,5` (0x00500093) and `add x2,x1,x1` (0x00108133) with ex_ready=1 → issued on consecutive cycles; ex_imm=5 then 0; issue_cnt=2; bubble_cnt=0.
- `lw x5,8(x2)` (0x00812283) followed by `add x6,x5,x0` (0x00028333) → one cycle with ex_valid=0 between the issues; bubble_cnt=1. Repeat with `lui x6,1` (0x00001337) → no bubble.
- Load to x0 (0x00012003) followed by a consumer of x0 → no bubble.
- Slot FULL with ex_ready=0 for 3 cycles, if_valid=1 → ex_inst/ex_pc/ex_imm held; if_ready=0; issue_cnt unchanged. Release → next instruction issues the following cycle.
- flush asserted while BUBBLE with if_valid=1 → next cycle EMPTY, ld_pending=0, incoming instruction dropped, no issue counted.
- Branch `beq x1,x2,-4` (0xFE208EE3) → ex_imm=0xFFFFFFFC. Opcode 0x0000007F → ex_illegal=1, ex_imm=0. Preload issue_cnt to all-ones and issue → 0. Assert rstn low mid-stall → all outputs 0 immediately.

Source files
------------

// File: rtl/id_issue_ctrl_if.sv
// IF-side and EX-side handshake bundle of the decode/issue stage.
// master is the issue controller, slave is the surrounding pipeline.
interface id_issue_ctrl_if;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_inst;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic        ex_illegal;

    modport master (
        input  if_valid, if_inst, if_pc, ex_ready,
        output if_ready, ex_valid, ex_inst, ex_pc, ex_imm,
        output ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_illegal
    );

    modport slave (
        output if_valid, if_inst, if_pc, ex_ready,
        input  if_ready, ex_valid, ex_inst, ex_pc, ex_imm,
        input  ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_illegal
    );
endinterface

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: one-entry ID slot, immediate generation,
// load-use bubble insertion and EX flush handling.
module id_issue_ctrl #(
    parameter int CNT_W   = 16,
    parameter int ISSUE_W = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    id_issue_ctrl_if.master    bus,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [ISSUE_W-1:0] issue_cnt
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {EMPTY, FULL, BUBBLE} state_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] i);
        logic [31:0] imm;
        imm = '0;
        unique case (i[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                imm = {{20{i[31]}}, i[31:20]};
            OP_STORE:
                imm = {{20{i[31]}}, i[31:25], i[11:7]};
            OP_BRANCH:
                imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {i[31:12], 12'b0};
            OP_JAL:
                imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:
                imm = '0;
        endcase
        return imm;
    endfunction

    function automatic logic supported(input logic [6:0] op);
        return op inside {OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH,
                          OP_LUI, OP_AUIPC, OP_JAL, OP_REG};
    endfunction

    // Hazard only when the instruction actually reads the pending load's rd.
    function automatic logic hazard(input logic [31:0] i,
                                    input logic        pend,
                                    input logic [4:0]  rd);
        logic use1;
        logic use2;
        use1 = supported(i[6:0]) &&
               !(i[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL});
        use2 = i[6:0] inside {OP_STORE, OP_BRANCH, OP_REG};
        return pend && (rd != 5'd0) &&
               ((use1 && i[19:15] == rd) || (use2 && i[24:20] == rd));
    endfunction

    state_t      state_q, state_d;
    logic [31:0] inst_q, pc_q;
    logic        ld_pending_q, ld_pending_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic        fire, load, bump;

    assign bus.ex_valid   = (state_q == FULL) && !flush;
    assign fire           = bus.ex_valid && bus.ex_ready;
    assign bus.if_ready   = rstn && !flush && ((state_q == EMPTY) || fire);
    assign load           = bus.if_valid && bus.if_ready;

    assign bus.ex_inst    = inst_q;
    assign bus.ex_pc      = pc_q;
    assign bus.ex_imm     = imm_gen(inst_q);
    assign bus.ex_rs1     = inst_q[19:15];
    assign bus.ex_rs2     = inst_q[24:20];
    assign bus.ex_rd      = inst_q[11:7];
    assign bus.ex_is_load = (inst_q[6:0] == OP_LOAD);
    assign bus.ex_illegal = (state_q != EMPTY) && !supported(inst_q[6:0]);

    always_comb begin
        state_d      = state_q;
        ld_pending_d = 1'b0;
        ld_rd_d      = ld_rd_q;
        bump         = 1'b0;
        if (fire && bus.ex_is_load && bus.ex_rd != 5'd0) begin
            ld_pending_d = 1'b1;
            ld_rd_d      = bus.ex_rd;
        end
        if (flush) begin
            state_d      = EMPTY;
            ld_pending_d = 1'b0;
        end else if (load) begin
            // Checked against the load issuing in this same cycle.
            state_d = hazard(bus.if_inst, ld_pending_d, ld_rd_d) ? BUBBLE
                                                                  : FULL;
        end else if (state_q == BUBBLE) begin
            state_d = FULL;
            bump    = 1'b1;
        end else if (fire) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= EMPTY;
            inst_q       <= '0;
            pc_q         <= '0;
            ld_pending_q <= 1'b0;
            ld_rd_q      <= '0;
            bubble_cnt   <= '0;
            issue_cnt    <= '0;
        end else begin
            state_q      <= state_d;
            ld_pending_q <= ld_pending_d;
            ld_rd_q      <= ld_rd_d;
            if (load) begin
                inst_q <= bus.if_inst;
                pc_q   <= bus.if_pc;
            end
            if (bump && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (fire)
                issue_cnt <= issue_cnt + ISSUE_W'(1);
        end
    end

    // ld_pending_q is kept for visibility; the hazard uses the next value.
    logic unused_ok;
    assign unused_ok = ld_pending_q;
endmodule

// File: tb/tb_id_issue_ctrl.sv
// Scoreboarded bench for id_issue_ctrl: table-driven stream plus
// stall, flush and mid-stall reset sequences.
module tb_id_issue_ctrl;
    logic       clk;
    logic       rstn;
    logic       flush;
    logic [1:0] bubble_cnt;
    logic [3:0] issue_cnt;

    id_issue_ctrl_if bus ();

    id_issue_ctrl #(.CNT_W(2), .ISSUE_W(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .bus       (bus),
        .bubble_cnt(bubble_cnt),
        .issue_cnt (issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic        ill;
        logic        ld;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        ill;
        logic        ld;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t       sb[$];
    vec_t       cur;
    int         n_chk;
    int         n_fail;
    int         cyc;
    logic [3:0] exp_iss;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Sample mid-low-phase: retire a fire against the scoreboard,
    // then record an accepted instruction.
    task automatic smp(output logic acc);
        exp_t e;
        logic [31:0] w;
        #2;
        acc = bus.if_valid && bus.if_ready;
        if (bus.ex_valid && bus.ex_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_issue: inst 0x%08h with empty scoreboard",
                         bus.ex_inst);
            end else begin
                e = sb.pop_front();
                w = e.inst;
                chk("issue_inst", bus.ex_inst, e.inst);
                chk("issue_pc", bus.ex_pc, e.pc);
                chk("issue_imm", bus.ex_imm, e.imm);
                chk("issue_illegal", 32'(bus.ex_illegal), 32'(e.ill));
                chk("issue_is_load", 32'(bus.ex_is_load), 32'(e.ld));
                chk("issue_rd", 32'(bus.ex_rd), 32'(w[11:7]));
                chk("issue_latency", cyc - e.acc_cyc, e.lat);
                chk("issue_cnt", 32'(issue_cnt), 32'(exp_iss));
                exp_iss = exp_iss + 4'd1;
            end
        end
        if (acc) begin
            e.inst    = bus.if_inst;
            e.pc      = bus.if_pc;
            e.imm     = cur.imm;
            e.ill     = cur.ill;
            e.ld      = cur.ld;
            e.lat     = cur.lat;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic adv();
        @(negedge clk);
        cyc++;
    endtask

    task automatic step(output logic acc);
        smp(acc);
        adv();
    endtask

    // Present one instruction until it is taken, bounded.
    task automatic send(input vec_t v, input logic [31:0] pc);
        logic acc;
        cur          = v;
        bus.if_valid = 1'b1;
        bus.if_inst  = v.inst;
        bus.if_pc    = pc;
        for (int k = 0; k < 12; k++) begin
            step(acc);
            if (acc) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: inst 0x%08h never accepted", v.inst);
    endtask

    task automatic drain();
        logic acc;
        bus.if_valid = 1'b0;
        for (int k = 0; k < 12 && sb.size() != 0; k++) step(acc);
        chk("drain_left", sb.size(), 0);
    endtask

    task automatic do_reset();
        flush        = 1'b0;
        bus.if_valid = 1'b0;
        bus.ex_ready = 1'b0;
        #2 rstn = 1'b0;
        sb.delete();
        exp_iss = '0;
        adv();
        rstn = 1'b1;
    endtask

    vec_t tbl[19];
    vec_t addi_v, add_v, lw_v, sub_v;
    logic acc;

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; exp_iss = '0;
        rstn = 1'b0; flush = 1'b0;
        bus.if_valid = 1'b0; bus.if_inst = '0; bus.if_pc = '0;
        bus.ex_ready = 1'b0;

        addi_v = '{32'h00500093, 32'd5,        1'b0, 1'b0, 1};
        add_v  = '{32'h00028333, 32'd0,        1'b0, 1'b0, 2};
        lw_v   = '{32'h00812283, 32'd8,        1'b0, 1'b1, 1};
        sub_v  = '{32'h00108133, 32'd0,        1'b0, 1'b0, 1};
        tbl[0]  = '{32'h00500093, 32'd5,        1'b0, 1'b0, 1};
        tbl[1]  = '{32'h00108133, 32'd0,        1'b0, 1'b0, 1};
        tbl[2]  = '{32'h00812283, 32'd8,        1'b0, 1'b1, 1};
        tbl[3]  = '{32'h00028333, 32'd0,        1'b0, 1'b0, 2};
        tbl[4]  = '{32'h00812283, 32'd8,        1'b0, 1'b1, 1};
        tbl[5]  = '{32'h00001337, 32'h00001000, 1'b0, 1'b0, 1};
        tbl[6]  = '{32'h00012003, 32'd0,        1'b0, 1'b1, 1};
        tbl[7]  = '{32'h000000B3, 32'd0,        1'b0, 1'b0, 1};
        tbl[8]  = '{32'hFE208EE3, 32'hFFFFFFFC, 1'b0, 1'b0, 1};
        tbl[9]  = '{32'h0000007F, 32'd0,        1'b1, 1'b0, 1};
        tbl[10] = '{32'h12345197, 32'h12345000, 1'b0, 1'b0, 1};
        tbl[11] = '{32'h010000EF, 32'd16,       1'b0, 1'b0, 1};
        tbl[12] = '{32'h00812283, 32'd8,        1'b0, 1'b1, 1};
        tbl[13] = '{32'h00512623, 32'd12,       1'b0, 1'b0, 2};
        tbl[14] = '{32'h00812283, 32'd8,        1'b0, 1'b1, 1};
        tbl[15] = '{32'h00028333, 32'd0,        1'b0, 1'b0, 2};
        tbl[16] = '{32'h00812283, 32'd8,        1'b0, 1'b1, 1};
        tbl[17] = '{32'h00028333, 32'd0,        1'b0, 1'b0, 2};
        tbl[18] = '{32'h00500093, 32'd5,        1'b0, 1'b0, 1};

        #3;
        chk("rst_if_ready", 32'(bus.if_ready), 0);
        chk("rst_ex_valid", 32'(bus.ex_valid), 0);
        chk("rst_ex_inst", bus.ex_inst, 0);
        chk("rst_ex_imm", bus.ex_imm, 0);
        chk("rst_ex_illegal", 32'(bus.ex_illegal), 0);
        chk("rst_bubble_cnt", 32'(bubble_cnt), 0);
        chk("rst_issue_cnt", 32'(issue_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Back-to-back stream: bubbles, x0 loads, imm forms, wrap, saturation.
        bus.ex_ready = 1'b1;
        for (int i = 0; i < 19; i++) send(tbl[i], 32'h1000 + 32'(4 * i));
        drain();
        chk("stream_bubble_sat", 32'(bubble_cnt), 3);
        chk("stream_issue_wrap", 32'(issue_cnt), 3);

        // Flush while a bubble is pending drops the incoming instruction.
        do_reset();
        bus.ex_ready = 1'b1;
        send(lw_v, 32'h2000);
        send(add_v, 32'h2004);
        sb.delete();
        flush = 1'b1;
        bus.if_valid = 1'b1;
        bus.if_inst = addi_v.inst;
        bus.if_pc = 32'h2008;
        smp(acc);
        chk("flush_ex_valid", 32'(bus.ex_valid), 0);
        chk("flush_if_ready", 32'(bus.if_ready), 0);
        adv();
        flush = 1'b0;
        bus.if_valid = 1'b0;
        smp(acc);
        chk("post_flush_ex_valid", 32'(bus.ex_valid), 0);
        chk("post_flush_if_ready", 32'(bus.if_ready), 1);
        chk("post_flush_issue_cnt", 32'(issue_cnt), 1);
        chk("post_flush_bubble_cnt", 32'(bubble_cnt), 0);
        adv();
        send(add_v, 32'h200C);
        sb.delete();
        flush = 1'b1;
        bus.if_valid = 1'b0;
        smp(acc);
        chk("flush_full_ex_valid", 32'(bus.ex_valid), 0);
        adv();
        flush = 1'b0;
        smp(acc);
        chk("flush_full_issue_cnt", 32'(issue_cnt), 1);
        adv();

        // Stall three cycles with the next instruction waiting.
        bus.ex_ready = 1'b0;
        addi_v.lat = 4;
        send(addi_v, 32'h3000);
        cur = sub_v;
        bus.if_valid = 1'b1;
        bus.if_inst = sub_v.inst;
        bus.if_pc = 32'h3004;
        for (int s = 0; s < 3; s++) begin
            smp(acc);
            chk("stall_ex_valid", 32'(bus.ex_valid), 1);
            chk("stall_if_ready", 32'(bus.if_ready), 0);
            chk("stall_ex_inst", bus.ex_inst, 32'h00500093);
            chk("stall_ex_pc", bus.ex_pc, 32'h3000);
            chk("stall_ex_imm", bus.ex_imm, 5);
            chk("stall_issue_cnt", 32'(issue_cnt), 1);
            adv();
        end
        bus.ex_ready = 1'b1;
        step(acc);
        chk("release_accept", 32'(acc), 1);
        drain();
        chk("release_issue_cnt", 32'(issue_cnt), 3);

        // Asynchronous reset in the middle of a stall.
        bus.ex_ready = 1'b0;
        send(lw_v, 32'h4000);
        bus.if_valid = 1'b1;
        bus.if_inst = sub_v.inst;
        smp(acc);
        chk("pre_rst_ex_valid", 32'(bus.ex_valid), 1);
        rstn = 1'b0;
        #1;
        chk("midrst_ex_valid", 32'(bus.ex_valid), 0);
        chk("midrst_if_ready", 32'(bus.if_ready), 0);
        chk("midrst_ex_inst", bus.ex_inst, 0);
        chk("midrst_ex_pc", bus.ex_pc, 0);
        chk("midrst_ex_imm", bus.ex_imm, 0);
        chk("midrst_ex_rd", 32'(bus.ex_rd), 0);
        chk("midrst_ex_is_load", 32'(bus.ex_is_load), 0);
        chk("midrst_issue_cnt", 32'(issue_cnt), 0);
        chk("midrst_bubble_cnt", 32'(bubble_cnt), 0);
        sb.delete();
        adv();
        rstn = 1'b1;
        bus.if_valid = 1'b0;
        smp(acc);
        chk("after_rst_ex_valid", 32'(bus.ex_valid), 0);
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
